// File: rtl/kbd_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package kbd_pkg;

  localparam int unsigned KEY_W = 4;
  localparam int unsigned COLS  = 4;
  localparam int unsigned ROWS  = 4;

  localparam logic [COLS-1:0] COL_RESET = 4'b1110;

  typedef enum logic [1:0] {
    StScan     = 2'd0,
    StDebounce = 2'd1,
    StPressed  = 2'd2
  } kbd_state_e;

  // Lowest-index low row wins when several rows are pulled down.
  function automatic logic [1:0] first_low(input logic [ROWS-1:0] rows);
    logic [1:0] idx;
    idx = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (!rows[i]) idx = i[1:0];
    end
    return idx;
  endfunction

  function automatic logic [1:0] col_index(input logic [COLS-1:0] cols_n);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < COLS; i++) begin
      if (!cols_n[i]) idx = i[1:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/scan_tick.sv
// Free-running prescaler producing a one-clk tick every TICK_DIV clocks.
module scan_tick #(
  parameter int unsigned TICK_DIV = 40000
) (
  input  logic clk_i,
  input  logic reset_i,
  output logic tick_o
);

  localparam int unsigned CntW = $clog2(TICK_DIV);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CntW'(TICK_DIV - 1));

  always_comb begin
    cnt_d = tick_o ? '0 : cnt_q + CntW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low key matrix scanner with tick-based debounce; one key_valid per press.
module keypad_scanner
  import kbd_pkg::*;
#(
  parameter int unsigned TICK_DIV       = 40000,
  parameter int unsigned DEBOUNCE_TICKS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ROWS-1:0]  row_n,
  output logic [COLS-1:0]  col_n,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  output logic             key_held
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_TICKS + 1);

  logic             tick;
  logic [ROWS-1:0]  row_meta_q, rows_s_q;
  kbd_state_e       state_q, state_d;
  logic [COLS-1:0]  col_n_q, col_n_d, col_rot;
  logic [1:0]       row_idx_q, row_idx_d, col_idx_q, col_idx_d;
  logic [CntW-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [KEY_W-1:0] key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q, key_held_d;
  logic             row_low;

  scan_tick #(
    .TICK_DIV(TICK_DIV)
  ) u_scan_tick (
    .clk_i  (clk),
    .reset_i(reset),
    .tick_o (tick)
  );

  assign col_rot = {col_n_q[COLS-2:0], col_n_q[COLS-1]};
  assign cnt_inc = cnt_q + CntW'(1);
  assign row_low = !rows_s_q[row_idx_q];

  always_comb begin
    state_d     = state_q;
    col_n_d     = col_n_q;
    row_idx_d   = row_idx_q;
    col_idx_d   = col_idx_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    if (tick) begin
      unique case (state_q)
        StScan: begin
          if (rows_s_q == '1) begin
            col_n_d = col_rot;
          end else begin
            row_idx_d = first_low(rows_s_q);
            col_idx_d = col_index(col_n_q);
            cnt_d     = '0;
            state_d   = StDebounce;
          end
        end
        StDebounce: begin
          if (row_low) begin
            if (cnt_inc == CntW'(DEBOUNCE_TICKS)) begin
              key_code_d  = {row_idx_q, col_idx_q};
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              cnt_d       = '0;
              state_d     = StPressed;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            // Bounce: abandon silently and move on to the next column.
            col_n_d = col_rot;
            state_d = StScan;
          end
        end
        StPressed: begin
          if (!row_low) begin
            if (cnt_inc == CntW'(DEBOUNCE_TICKS)) begin
              key_held_d = 1'b0;
              cnt_d      = '0;
              col_n_d    = col_rot;
              state_d    = StScan;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cnt_d = '0;
          end
        end
        default: state_d = StScan;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_meta_q  <= '1;
      rows_s_q    <= '1;
      state_q     <= StScan;
      col_n_q     <= COL_RESET;
      row_idx_q   <= '0;
      col_idx_q   <= '0;
      cnt_q       <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      row_meta_q  <= row_n;
      rows_s_q    <= row_meta_q;
      state_q     <= state_d;
      col_n_q     <= col_n_d;
      row_idx_q   <= row_idx_d;
      col_idx_q   <= col_idx_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign col_n     = col_n_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Input-side counterpart of the multiplexed 7-segment display driver.
- Scans a 4x4 active-low key matrix by driving one column low at a time. It reads the four row lines, debounces the press, and emits one key code per physical press.
- Sits between the board key matrix pins and the calculator entry logic.
- Uses the same clk and reset as the display block.

Parameters:
- TICK_DIV, 40000, clk cycles per scan tick (400 Hz at 16 MHz); legal range >= 2.
- DEBOUNCE_TICKS, 4, consecutive stable ticks required to accept a press or a release; legal range >= 1.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- row_n  input  4  matrix row lines, active low, asynchronous to clk.
- col_n  output  4  column drive, one-cold active low.
- key_code  output  4  last accepted key, {row_idx[1:0], col_idx[1:0]}.
- key_valid  output  1  one-clk pulse when key_code is updated.
- key_held  output  1  high while the accepted key remains pressed.

Behaviour:
- Reset values (applied on the clk edge where reset=1):
  - col_n=4'b1110, key_code=0, key_valid=0, key_held=0.
  - State=SCAN, tick and debounce counters=0, row synchronizer flops=4'b1111.
- Synchronizer: row_n passes through a 2-flop synchronizer; rows_s is its output. All decisions use rows_s.
- Tick generator:
  - Counter runs 0..TICK_DIV-1; tick=1 for one clk when the counter equals TICK_DIV-1.
  - Free-running; restarts from 0 after reset.
- Row sampling and priority:
  - Rows are evaluated only on tick cycles. The active column has then been driven for a full tick period, so settling is guaranteed.
  - If several rows are low, the lowest row index wins.
- SCAN state:
  - On tick with rows_s==4'b1111: rotate col_n left by 1 (1110->1101->1011->0111->1110).
  - On tick with any row low: latch row_idx (priority) and col_idx, clear the debounce counter, hold col_n, go to DEBOUNCE.
- DEBOUNCE state (col_n held):
  - On tick, if the latched row is still low, increment the counter.
  - On tick, if the latched row is high: go to SCAN and rotate col_n to the next column. No output is produced.
  - When the counter reaches DEBOUNCE_TICKS:
    - key_code <= {row_idx, col_idx}.
    - key_valid=1 for exactly one clk.
    - key_held <= 1.
    - Clear the counter and go to PRESSED.
- PRESSED state (col_n held):
  - On tick with the latched row high, increment the counter.
  - On tick with the latched row low, clear the counter.
  - When the counter reaches DEBOUNCE_TICKS: key_held <= 0, rotate col_n, go to SCAN.
  - Presses on other keys in the same or other columns are ignored; there is no rollover.
- key_code holds its value until the next accepted press.
- key_valid is never asserted in two consecutive clks.
- Reset mid-operation: immediate return to the reset values. No key_valid is emitted, even if reset is released with a key still down; that key is then re-detected through SCAN/DEBOUNCE.
- Latency from a stable press (as seen at rows_s) to key_valid: at most 4*TICK_DIV + DEBOUNCE_TICKS*TICK_DIV + 1 clk.

Decomposition:
- Shared package kbd_pkg holds:
  - State encoding: SCAN=2'd0, DEBOUNCE=2'd1, PRESSED=2'd2.
  - KEY_W=4, COLS=4, ROWS=4.
  - Column reset pattern 4'b1110.
- One sub-module, scan_tick: parameterised TICK_DIV divider with synchronous reset and a one-clk tick output. It mirrors the display's prescaler.
- Key-code-to-calculator-symbol mapping lives outside this block.

Test Plan:
(All scenarios use TICK_DIV=4, DEBOUNCE_TICKS=3.)
- Reset, no keys: col_n sequence 1110,1101,1011,0111,1110 advances every 4 clk; key_valid never asserts; key_held=0.
- Hold the key at row 2/col 1 (row_n[2]=0 while col_n[1]=0, for 40 clk) -> exactly one key_valid pulse with key_code=4'b1001; key_held=1; col_n frozen at 1101. Release -> key_held=0 after 3 stable ticks; scanning resumes at 1011.
- Bounce: row low for 1 tick, high on the next tick, during DEBOUNCE -> no key_valid; col_n advances to the next column.
- Rows 1 and 3 low together in column 0 -> key_code=4'b0100; a single key_valid.
- Release glitch in PRESSED: row high 2 ticks, low 1 tick, high 3 ticks -> key_held drops only after the final 3-tick run; no second key_valid.
- Reset asserted in PRESSED with the key still held -> next clk: col_n=1110, key_held=0, key_valid=0. After release of reset the key is re-accepted with one new key_valid.
